stage_fetch: RTL and testbench

- Instruction fetch stage; sits directly upstream of stage_decode and drives its pc_i and instr inputs.
- Holds the fetch PC, issues sequential word requests to instruction memory, and accepts in-order responses of variable latency.
- Buffers fetched instructions in a small FIFO so that decode stalls do not lose data.
- Handles redirects from branch/jump resolution by flushing the FIFO and discarding stale in-flight responses.

---
 rtl/stage_fetch_if.sv | 26 ++
 rtl/stage_fetch.sv | 146 ++++++++++++++
 tb/tb_stage_fetch.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/stage_fetch_if.sv
// Instruction-memory request/response bundle between stage_fetch (master) and the memory (slave).
interface stage_fetch_if #(
    parameter int INSTR_SIZE = 32
) ();
    logic                  imem_req_valid;
    logic                  imem_req_ready;
    logic [INSTR_SIZE-1:0] imem_req_addr;
    logic                  imem_rsp_valid;
    logic [INSTR_SIZE-1:0] imem_rsp_data;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data
    );
endinterface

// File: rtl/stage_fetch.sv
// Instruction fetch stage: sequential PC requests, in-order responses into a small FIFO, redirect flush.
// Optional macro FETCH_PERF_EN adds perf_fetched / perf_bubbles counters.
//
// state | meaning
// BOOT  | one-cycle bubble after reset, no request
// RUN   | issue requests while credit allows
// DRAIN | discard stale in-flight responses after a redirect
module stage_fetch #(
    parameter int                  INSTR_SIZE      = 32,
    parameter logic [INSTR_SIZE-1:0] RESET_PC      = '0,
    parameter int                  BUF_DEPTH       = 4,
    parameter int                  MAX_OUTSTANDING = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    stage_fetch_if.master         imem,
    input  logic                  redirect_valid,
    input  logic [INSTR_SIZE-1:0] redirect_pc,
    input  logic                  stall,
    output logic                  instr_valid,
    output logic [INSTR_SIZE-1:0] instr,
    output logic [INSTR_SIZE-1:0] pc_o
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]           perf_fetched,
    output logic [31:0]           perf_bubbles
`endif
);
    localparam int PW = $clog2(BUF_DEPTH);
    localparam int CW = PW + 1;

    typedef logic [CW-1:0] cnt_t;
    typedef logic [PW-1:0] ptr_t;
    typedef enum logic [1:0] {BOOT, RUN, DRAIN} state_t;

    localparam cnt_t        MAX_OUT_C = cnt_t'(MAX_OUTSTANDING);
    localparam logic [CW:0] DEPTH_C   = (CW+1)'(BUF_DEPTH);
    localparam logic [INSTR_SIZE-1:0] WORD_C = INSTR_SIZE'(4);

    state_t                state_q, state_d;
    logic [INSTR_SIZE-1:0] fetch_pc_q, fetch_pc_d;
    logic [INSTR_SIZE-1:0] rsp_pc_q, rsp_pc_d;
    cnt_t                  out_q, out_d;
    cnt_t                  drop_q, drop_d;
    cnt_t                  count_q, count_d;
    ptr_t                  wr_ptr_q, wr_ptr_d;
    ptr_t                  rd_ptr_q, rd_ptr_d;
    logic [INSTR_SIZE-1:0] pc_mem_q   [BUF_DEPTH];
    logic [INSTR_SIZE-1:0] data_mem_q [BUF_DEPTH];

    logic req_valid, req_fire, rsp_fire, push, pop, credit_ok;
    logic [INSTR_SIZE-1:0] target_pc;

    always_comb begin
        state_d    = state_q;
        req_valid  = 1'b0;
        target_pc  = redirect_pc & ~INSTR_SIZE'(3);
        // Credit covers in-flight requests so every response is guaranteed a FIFO slot.
        credit_ok  = (out_q < MAX_OUT_C) && (({1'b0, count_q} + {1'b0, out_q}) < DEPTH_C);

        case (state_q)
            BOOT:    state_d = RUN;
            RUN:     req_valid = credit_ok;
            DRAIN:   if (drop_q == '0) state_d = RUN;
            default: state_d = BOOT;
        endcase

        req_fire = req_valid && imem.imem_req_ready;
        rsp_fire = imem.imem_rsp_valid && (out_q != '0);
        push     = rsp_fire && (drop_q == '0) && !redirect_valid;
        pop      = (count_q != '0) && !stall && !redirect_valid;

        out_d      = out_q + cnt_t'(req_fire) - cnt_t'(rsp_fire);
        drop_d     = (rsp_fire && drop_q != '0) ? drop_q - cnt_t'(1) : drop_q;
        fetch_pc_d = req_fire ? fetch_pc_q + WORD_C : fetch_pc_q;
        rsp_pc_d   = push ? rsp_pc_q + WORD_C : rsp_pc_q;
        count_d    = count_q + cnt_t'(push) - cnt_t'(pop);
        wr_ptr_d   = push ? wr_ptr_q + ptr_t'(1) : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + ptr_t'(1) : rd_ptr_q;

        // Everything still in flight after this edge, including a request accepted now, is stale.
        if (redirect_valid) begin
            fetch_pc_d = target_pc;
            rsp_pc_d   = target_pc;
            drop_d     = out_d;
            count_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            state_d    = (out_d != '0) ? DRAIN : RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= BOOT;
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            out_q      <= '0;
            drop_q     <= '0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                pc_mem_q[i]   <= '0;
                data_mem_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            out_q      <= out_d;
            drop_q     <= drop_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            if (push) begin
                pc_mem_q[wr_ptr_q]   <= rsp_pc_q;
                data_mem_q[wr_ptr_q] <= imem.imem_rsp_data;
            end
        end
    end

    assign imem.imem_req_valid = req_valid;
    assign imem.imem_req_addr  = fetch_pc_q;
    assign instr_valid         = (count_q != '0);
    assign instr               = data_mem_q[rd_ptr_q];
    assign pc_o                = pc_mem_q[rd_ptr_q];

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched_q, perf_bubbles_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            perf_fetched_q <= '0;
            perf_bubbles_q <= '0;
        end else begin
            if (pop) perf_fetched_q <= perf_fetched_q + 32'd1;
            if ((count_q == '0) && !stall && (state_q != BOOT))
                perf_bubbles_q <= perf_bubbles_q + 32'd1;
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_bubbles = perf_bubbles_q;
`endif
endmodule

// File: tb/tb_stage_fetch.sv
// Scoreboard bench for stage_fetch: memory model with variable latency, expected (pc, word) queue.
module tb_stage_fetch;
    localparam logic [31:0] RST_PC = 32'h0000_1000;

    typedef struct packed { logic [31:0] addr; int due; } mreq_t;
    typedef struct packed { logic [31:0] pc; logic [31:0] data; } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n, redirect_valid, stall, instr_valid;
    logic [31:0] redirect_pc, instr, pc_o;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched, perf_bubbles;
`endif

    stage_fetch_if #(.INSTR_SIZE(32)) bus ();

    stage_fetch #(
        .INSTR_SIZE(32), .RESET_PC(RST_PC), .BUF_DEPTH(4), .MAX_OUTSTANDING(2)
    ) dut (
        .clk(clk), .reset_n(reset_n), .imem(bus),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .stall(stall),
        .instr_valid(instr_valid), .instr(instr), .pc_o(pc_o)
`ifdef FETCH_PERF_EN
        , .perf_fetched(perf_fetched), .perf_bubbles(perf_bubbles)
`endif
    );

    int n_chk = 0, n_fail = 0;
    int cyc = 0, lat = 1, model_out = 0, pops = 0;
    logic rst_v, stall_v, redir_v, ready_v;
    logic [31:0] redir_pc_v, model_pc, arm_pc, prev_fire_addr;
    bit arm, hit, want_first, got_first, wrap_seen;
    logic [31:0] first_pop_pc, first_pop_data;
    logic obs_req_valid, obs_iv;
    logic [31:0] obs_req_addr, obs_pc;
    mreq_t mem_q[$];
    exp_t  exp_q[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h", tag, act, exp);
        end
    endtask

    task automatic cycle();
        logic fire, popping;
        exp_t e;
        @(negedge clk);
        cyc++;
        reset_n            = rst_v;
        stall              = stall_v;
        redirect_valid     = redir_v;
        redirect_pc        = redir_pc_v;
        bus.imem_req_ready = ready_v;
        if (!rst_v) begin
            mem_q.delete();
            exp_q.delete();
            model_out = 0;
            model_pc  = RST_PC;
            pops      = 0;
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data  = '0;
        end else begin
            if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
                bus.imem_rsp_valid = 1'b1;
                bus.imem_rsp_data  = mem_word(mem_q[0].addr);
                void'(mem_q.pop_front());
                model_out--;
            end else begin
                bus.imem_rsp_valid = 1'b0;
                bus.imem_rsp_data  = '0;
            end
            #1;
            fire = bus.imem_req_valid && bus.imem_req_ready;
            if (arm && bus.imem_rsp_valid && fire) begin
                redirect_valid = 1'b1;
                redirect_pc    = arm_pc;
                arm = 0; hit = 1; want_first = 1; got_first = 0;
            end
            obs_req_valid = bus.imem_req_valid;
            obs_req_addr  = bus.imem_req_addr;
            obs_iv        = instr_valid;
            obs_pc        = pc_o;
            if (fire) begin
                chk("req_addr", bus.imem_req_addr, model_pc);
                if (prev_fire_addr == 32'hFFFF_FFFC && bus.imem_req_addr == 32'h0) wrap_seen = 1;
                prev_fire_addr = bus.imem_req_addr;
                mem_q.push_back('{addr: bus.imem_req_addr, due: cyc + lat});
                model_out++;
                if (!redirect_valid)
                    exp_q.push_back('{pc: bus.imem_req_addr, data: mem_word(bus.imem_req_addr)});
                model_pc = model_pc + 32'd4;
            end
            popping = instr_valid && !stall && !redirect_valid;
            if (popping) begin
                pops++;
                if (exp_q.size() == 0) begin
                    chk("pop_unexpected", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("pop_pc", pc_o, e.pc);
                    chk("pop_instr", instr, e.data);
                end
                if (want_first && !got_first) begin
                    got_first = 1; first_pop_pc = pc_o; first_pop_data = instr;
                end
            end
            if (redirect_valid) begin
                exp_q.delete();
                model_pc = redirect_pc & ~32'h3;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_first(input int budget);
        for (int i = 0; i < budget && !got_first; i++) cycle();
    endtask

    initial begin
        rst_v = 0; stall_v = 0; redir_v = 0; redir_pc_v = '0; ready_v = 1;
        reset_n = 0; stall = 0; redirect_valid = 0; redirect_pc = '0;
        bus.imem_req_ready = 1; bus.imem_rsp_valid = 0; bus.imem_rsp_data = '0;
        arm = 0; hit = 0; want_first = 0; got_first = 0; wrap_seen = 0;
        prev_fire_addr = '0; model_pc = RST_PC; arm_pc = '0;

        repeat (3) cycle();
        chk("rst_req_valid", bus.imem_req_valid, 1'b0);
        chk("rst_req_addr", bus.imem_req_addr, RST_PC);
        chk("rst_instr_valid", instr_valid, 1'b0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_pc_o", pc_o, 32'h0);

        rst_v = 1;
        cycle(); chk("boot_bubble", obs_req_valid, 1'b0);
        cycle(); chk("first_req_valid", obs_req_valid, 1'b1);
                 chk("first_req_addr", obs_req_addr, RST_PC);
        cycle(); chk("first_latency", obs_iv, 1'b0);
        cycle(); chk("seq_pc0", obs_pc, RST_PC);
                 chk("seq_valid0", obs_iv, 1'b1);
        cycle(); chk("seq_pc1", obs_pc, RST_PC + 32'd4);
        cycle(); chk("seq_pc2", obs_pc, RST_PC + 32'd8);

        stall_v = 1;
        repeat (10) cycle();
        chk("stall_full_noreq", obs_req_valid, 1'b0);
        chk("stall_holds_valid", obs_iv, 1'b1);
        begin
            int p0;
            p0 = pops; ready_v = 0; stall_v = 0;
            repeat (6) cycle();
            chk("stall_buffered", pops - p0, 4);
        end

        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("hold_valid", obs_req_valid, 1'b1);
            chk("hold_addr", obs_req_addr, model_pc);
        end
        ready_v = 1;

        lat = 3;
        for (int i = 0; i < 20 && model_out != 2; i++) cycle();
        chk("two_outstanding", model_out, 2);
        redir_v = 1; redir_pc_v = 32'h0000_2002; want_first = 1; got_first = 0;
        cycle();
        redir_v = 0;
        cycle(); chk("drain_noreq", obs_req_valid, 1'b0);
        wait_first(40);
        chk("redir_seen", got_first, 1'b1);
        chk("redir_first_pc", first_pop_pc, 32'h0000_2000);
        chk("redir_first_data", first_pop_data, mem_word(32'h0000_2000));
        want_first = 0;

        lat = 2;
        repeat (6) cycle();
        arm = 1; arm_pc = 32'h0000_3001; hit = 0;
        for (int i = 0; i < 30 && !hit; i++) cycle();
        chk("coincide_hit", hit, 1'b1);
        arm = 0;
        wait_first(40);
        chk("coincide_first_pc", first_pop_pc, 32'h0000_3000);
        want_first = 0;

        lat = 1;
        redir_v = 1; redir_pc_v = 32'hFFFF_FFF4;
        cycle();
        redir_v = 0;
        repeat (12) cycle();
        chk("wrap_seen", wrap_seen, 1'b1);

        for (int i = 0; i < 300; i++) begin
            stall_v = ($urandom_range(0, 3) == 0);
            ready_v = ($urandom_range(0, 3) != 0);
            lat     = $urandom_range(1, 4);
            redir_v = ($urandom_range(0, 24) == 0);
            redir_pc_v = $urandom;
            cycle();
        end
        redir_v = 0; stall_v = 0; ready_v = 1; lat = 1;
        repeat (20) cycle();
        chk("drained_valid", obs_iv, 1'b1);
`ifdef FETCH_PERF_EN
        chk("perf_fetched", perf_fetched, pops);
`endif

        rst_v = 0;
        cycle(); cycle();
        chk("midrst_instr_valid", instr_valid, 1'b0);
        chk("midrst_req_valid", bus.imem_req_valid, 1'b0);
        chk("midrst_req_addr", bus.imem_req_addr, RST_PC);
        rst_v = 1; want_first = 1; got_first = 0;
        wait_first(20);
        chk("midrst_first_pc", first_pop_pc, RST_PC);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
